// File: rtl/edid_ddc_slave.sv
// DDC/EDID I2C target: answers reads at DEV_ADDR from an external 256-byte ROM; writes after the word address are NACKed.
// Filtered inputs add 2+FILTER_LEN cycles; SDA updates one cycle after each filtered SCL fall; never stretches the clock.
module edid_ddc_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       nrst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       scl_oe,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       byte_stb
);

  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, DEVADDR, DEVACK, WORDADDR, WORDACK, WRIGNORE, TXBYTE, MACK
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_d, sda_d;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge sys_clk) begin
    if (!nrst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FLT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 4'd1;
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FLT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 4'd1;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] shreg, shreg_nx, offset, offset_nx;
  logic       rw, rw_nx, load_pend, load_pend_nx;
  logic       oe_nx, busy_nx, stb_nx, do_load;

  always_ff @(posedge sys_clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      offset    <= '0;
      rw        <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      byte_stb  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      offset    <= offset_nx;
      rw        <= rw_nx;
      load_pend <= load_pend_nx;
      sda_oe    <= oe_nx;
      busy      <= busy_nx;
      byte_stb  <= stb_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    offset_nx    = offset;
    rw_nx        = rw;
    load_pend_nx = load_pend;
    oe_nx        = sda_oe;
    busy_nx      = busy;
    stb_nx       = 1'b0;
    do_load      = 1'b0;
    if (stop_c) begin
      state_nx     = IDLE;
      oe_nx        = 1'b0;
      busy_nx      = 1'b0;
      load_pend_nx = 1'b0;
    end else if (start_c) begin
      state_nx     = DEVADDR;
      cnt_nx       = '0;
      oe_nx        = 1'b0;
      busy_nx      = 1'b0;
      load_pend_nx = 1'b0;
    end else begin
      case (state)
        IDLE: oe_nx = 1'b0;
        DEVADDR, WORDADDR: begin
          if (scl_rise && cnt != 4'd8) begin
            shreg_nx = {shreg[6:0], sda_f};
            cnt_nx   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (state == WORDADDR) begin
              offset_nx = shreg;
              state_nx  = WORDACK;
              oe_nx     = 1'b1;
            end else if (shreg[7:1] == DEV_ADDR) begin
              state_nx = DEVACK;
              oe_nx    = 1'b1;
              busy_nx  = 1'b1;
              rw_nx    = shreg[0];
            end else begin
              state_nx = IDLE;
            end
          end
        end
        DEVACK: begin
          if (scl_fall) begin
            if (rw) do_load = 1'b1;
            else begin
              state_nx = WORDADDR;
              oe_nx    = 1'b0;
              cnt_nx   = '0;
            end
          end
        end
        WORDACK: begin
          if (scl_fall) begin
            state_nx = WRIGNORE;
            oe_nx    = 1'b0;
          end
        end
        WRIGNORE: oe_nx = 1'b0;
        TXBYTE: begin
          if (scl_fall) begin
            if (load_pend) do_load = 1'b1;
            else if (cnt == 4'd7) begin
              state_nx = MACK;
              oe_nx    = 1'b0;
            end else begin
              shreg_nx = {shreg[6:0], 1'b0};
              oe_nx    = ~shreg[6];
              cnt_nx   = cnt + 4'd1;
            end
          end
        end
        MACK: begin
          oe_nx = 1'b0;
          // Next byte is fetched at the SCL fall that closes the master's ACK.
          if (scl_rise) begin
            if (!sda_f) begin
              state_nx     = TXBYTE;
              load_pend_nx = 1'b1;
            end else state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
      if (do_load) begin
        state_nx     = TXBYTE;
        shreg_nx     = rom_data;
        stb_nx       = 1'b1;
        offset_nx    = offset + 8'd1;
        oe_nx        = ~rom_data[7];
        cnt_nx       = '0;
        load_pend_nx = 1'b0;
      end
    end
  end

  assign scl_out  = 1'b0;
  assign scl_oe   = 1'b0;
  assign sda_out  = 1'b0;
  assign rom_addr = offset;

endmodule

// File: tb/tb_edid_ddc_slave.sv
// Directed bench for edid_ddc_slave: bit-banged I2C master, open-drain SDA bus and a registered ROM model.
module tb_edid_ddc_slave;
  localparam int Q  = 10;
  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       scl_out, scl_oe, sda_out, sda_oe, busy, byte_stb;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  assign sda_bus = sda_m & ~sda_oe;

  edid_ddc_slave #(.DEV_ADDR(7'h50), .FILTER_LEN(FL)) dut (
    .sys_clk(clk), .nrst(nrst), .scl_in(scl_m), .sda_in(sda_bus),
    .scl_out(scl_out), .scl_oe(scl_oe), .sda_out(sda_out), .sda_oe(sda_oe),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .byte_stb(byte_stb)
  );

  always #5 clk = ~clk;

  // ROM contents: byte[a] = a*37 + 0x5A (mod 256).
  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return a * 8'd37 + 8'h5A;
  endfunction

  always @(posedge clk) begin
    rom_data <= rom_val(rom_addr);
    if (nrst && byte_stb) stb_cnt <= stb_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, input logic glitch, output logic r);
    wq(Q);
    sda_m = b;
    if (glitch) begin
      wq(3);
      scl_m = 1'b1;
      wq(FL - 1);
      scl_m = 1'b0;
      wq(Q - 3 - (FL - 1));
    end else wq(Q);
    scl_m = 1'b1;
    wq(Q);
    r = sda_bus;
    wq(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], i == gbit, r);
    sbit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      sbit(1'b1, 1'b0, r);
      acc = {acc[6:0], r};
    end
    sbit(nack, 1'b0, r);
    d = acc;
  endtask

  task automatic sr();
    wq(Q); sda_m = 1'b1;
    wq(Q); scl_m = 1'b1;
    wq(Q); sda_m = 1'b0;
    wq(Q); scl_m = 1'b0;
  endtask

  task automatic sp();
    wq(Q); sda_m = 1'b0;
    wq(Q); scl_m = 1'b1;
    wq(Q); sda_m = 1'b1;
    wq(Q);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    logic [2:0] bits;
    int         s0, o0, b0;

    wq(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte_stb", byte_stb, 0);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("static_outs", {scl_out, scl_oe, sda_out}, 3'b000);
    nrst = 1'b1;
    wq(5);

    // Random read of ROM[0..3]
    s0 = stb_cnt;
    sr();
    write_byte(8'hA0, -1, ack); chk("rr_ack_dev_w", ack, 1);
    write_byte(8'h00, -1, ack); chk("rr_ack_word", ack, 1);
    sr();
    write_byte(8'hA1, -1, ack); chk("rr_ack_dev_r", ack, 1);
    chk("rr_busy", busy, 1);
    read_byte(1'b0, d); chk("rr_d0", d, 8'h5A);
    read_byte(1'b0, d); chk("rr_d1", d, 8'h7F);
    read_byte(1'b0, d); chk("rr_d2", d, 8'hA4);
    read_byte(1'b1, d); chk("rr_d3", d, 8'hC9);
    sp();
    chk("rr_stb_count", stb_cnt - s0, 4);
    chk("rr_rom_addr", rom_addr, 8'h04);
    chk("rr_busy_after_stop", busy, 0);

    // Current-address read continues at 4
    sr();
    write_byte(8'hA1, -1, ack); chk("ca_ack", ack, 1);
    read_byte(1'b0, d); chk("ca_d0", d, 8'hEE);
    read_byte(1'b1, d); chk("ca_d1", d, 8'h13);
    sp();

    // Offset wraps 0xFF -> 0x00
    s0 = stb_cnt;
    sr();
    write_byte(8'hA0, -1, ack);
    write_byte(8'hFE, -1, ack); chk("wr_ack_word", ack, 1);
    sr();
    write_byte(8'hA1, -1, ack);
    read_byte(1'b0, d); chk("wr_dFE", d, 8'h10);
    read_byte(1'b0, d); chk("wr_dFF", d, 8'h35);
    read_byte(1'b1, d); chk("wr_d00", d, 8'h5A);
    sp();
    chk("wr_stb_count", stb_cnt - s0, 3);
    chk("wr_rom_addr", rom_addr, 8'h01);

    // Foreign address is ignored entirely
    o0 = oe_cnt; b0 = busy_cnt;
    sr();
    write_byte(8'hA4, -1, ack); chk("wa_nack", ack, 0);
    write_byte(8'h00, -1, ack);
    sp();
    chk("wa_sda_oe_cycles", oe_cnt - o0, 0);
    chk("wa_busy_cycles", busy_cnt - b0, 0);

    // Data write after the word address is NACKed, offset still loaded
    sr();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h10, -1, ack); chk("wd_ack_word", ack, 1);
    write_byte(8'h55, -1, ack); chk("wd_data_nack", ack, 0);
    sp();
    chk("wd_rom_addr", rom_addr, 8'h10);

    // STOP after 3 bits of ROM[0x20] = 0xFA
    sr();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h20, -1, ack);
    sr();
    write_byte(8'hA1, -1, ack);
    for (int i = 0; i < 3; i++) begin
      sbit(1'b1, 1'b0, r);
      bits = {bits[1:0], r};
    end
    chk("ab_bits", bits, 3'b111);
    sp();
    chk("ab_sda_oe", sda_oe, 0);
    chk("ab_busy", busy, 0);
    chk("ab_rom_addr", rom_addr, 8'h21);

    // Reset while driving bit 7 (0) of ROM[0]
    sr();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h00, -1, ack);
    sr();
    write_byte(8'hA1, -1, ack);
    wq(Q);
    chk("rs_driving_low", sda_oe, 1);
    nrst = 1'b0;
    wq(1);
    chk("rs_sda_oe", sda_oe, 0);
    chk("rs_busy", busy, 0);
    chk("rs_rom_addr", rom_addr, 8'h00);
    wq(3);
    nrst = 1'b1;
    wq(2 * Q);

    // Short SCL glitch during the device address is filtered out
    sr();
    write_byte(8'hA0, 2, ack); chk("gl_ack_dev", ack, 1);
    write_byte(8'h05, -1, ack); chk("gl_ack_word", ack, 1);
    sr();
    write_byte(8'hA1, -1, ack); chk("gl_ack_dev_r", ack, 1);
    read_byte(1'b1, d); chk("gl_d5", d, 8'h13);
    sp();
    chk("gl_rom_addr", rom_addr, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edid_ddc_slave.md
# edid_ddc_slave

DDC/EDID responder for the HDMI receive port: an I2C target that answers the upstream source's EDID reads over FPGA_HDMI_SCL/SDA, with data fetched from an external 256-byte EDID ROM. It sits between the HDMI DDC I/O pins (open-drain IN/OUT/OE triplets) and the EDID ROM, alongside the HDMI RX path and HPD_N.

## Interface
- DEV_ADDR, 7'h50, 7-bit I2C address answered (8'hA0 write / 8'hA1 read)
- FILTER_LEN, 4, consecutive identical sys_clk samples required to accept an SCL/SDA level change (range 1–15)
- sys_clk  in  1  block clock; must be at least 40 × SCL frequency
- nrst  in  1  synchronous, active-low reset
- scl_in  in  1  SCL pad input (asynchronous)
- sda_in  in  1  SDA pad input (asynchronous)
- scl_out  out  1  constant 0
- scl_oe  out  1  constant 0; no clock stretching
- sda_out  out  1  constant 0 (open-drain)
- sda_oe  out  1  1 = pull SDA low
- rom_addr  out  8  EDID ROM byte address (current offset)
- rom_data  in  8  ROM data; valid one sys_clk after rom_addr changes
- busy  out  1  1 from an address-matched ACK until the next STOP/START
- byte_stb  out  1  one-cycle pulse for each data byte loaded for transmission

## Operation
- Input conditioning: two-flop synchronizer per line, then a FILTER_LEN counter filter producing scl_f/sda_f (reset value 1). Edge detectors on the filtered signals drive all decoding.
- START = sda_f falls while scl_f = 1; STOP = sda_f rises while scl_f = 1. Both are recognised in every state and take priority over bit handling.
- State machine: IDLE, DEVADDR, DEVACK, WORDADDR, WORDACK, WRIGNORE, TXBYTE, MACK.
  - IDLE: sda_oe = 0; START -> DEVADDR.
  - DEVADDR: shift 8 bits MSB-first on scl_f rising. If [7:1] == DEV_ADDR, go to DEVACK; otherwise release SDA and wait in IDLE for the next START.
  - DEVACK: assert sda_oe for the ninth clock. Then go to WORDADDR if R/W = 0, or to TXBYTE if R/W = 1.
  - WORDADDR: shift 8 bits, load them into the offset register, then go to WORDACK (ACK) -> WRIGNORE.
  - WRIGNORE: further written bytes are NACKed (SDA released) and discarded. The EDID is read-only.
  - TXBYTE: at the scl_f falling edge that ends the ACK, load the shift register from rom_data, pulse byte_stb, and increment the offset modulo 256 (0xFF -> 0x00). Drive sda_oe = ~bit, MSB first, updated one sys_clk after each scl_f falling edge. After bit 0, go to MACK.
  - MACK: release SDA and sample sda_f on scl_f rising. 0 = ACK -> TXBYTE (next byte). 1 = NACK -> IDLE, SDA released, waiting for STOP/START.
- Repeated START from any state -> DEVADDR. The offset is retained, so a current-address read continues from the last offset.
- STOP in any state -> IDLE, sda_oe = 0 within 1 cycle, busy = 0. The offset is retained.
- rom_addr always equals the offset register.

## Timing
- Reset values: sda_oe = 0, busy = 0, byte_stb = 0, rom_addr = 0x00, offset = 0x00, state IDLE, scl_f = sda_f = 1.
- Pad-to-filtered latency: 2 + FILTER_LEN sys_clk.
- SDA drive changes exactly 1 sys_clk after the filtered scl_f falling edge is detected, and never while scl_f = 1 (except release on STOP/reset).
- ROM access: rom_addr is stable ≥ 1 SCL bit time before rom_data is sampled, so the one-cycle ROM latency is always met.
- Reset mid-transfer: on the first nrst = 0 cycle, sda_oe = 0; all state returns to the reset values.
- Simultaneous START/STOP detection with a bit edge: the condition wins and the bit is discarded.

## Test plan
- Random read: START, A0, 00, Sr, A1, read 4 bytes (ACK, ACK, ACK, NACK), STOP. Required: ACKs at device address, word address and second device address; returned bytes = ROM[0..3]; byte_stb pulses 4 times; rom_addr = 0x04 afterwards.
- Current-address read: then START, A1, read 2 bytes, NACK. Required: returns ROM[4], ROM[5].
- Wrap: word address 0xFE, read 3 bytes. Required: returns ROM[0xFE], ROM[0xFF], ROM[0x00].
- Wrong address: START, A4. Required: no ACK, sda_oe stays 0 for the whole transfer, busy stays 0.
- Abort: STOP after 3 bits of a TXBYTE. Required: sda_oe = 0 within 1 cycle of STOP detection, state IDLE. Reset asserted mid-byte gives the same result, and rom_addr = 0.
- Glitch: an SCL pulse of FILTER_LEN−1 cycles during DEVADDR. Required: ignored, and the address still decodes correctly. A write of a data byte after the word address is NACKed.
